ecc_secded_pipe: RTL
====================

Name: ecc_secded_pipe

Overview:
- Parametrised SECDED (single-error-correct, double-error-detect) extended-Hamming codec for the memory controller datapath.
- Write path: registered encoder. Read path: 2-stage pipelined decoder/corrector.
- Both paths use valid/ready handshakes with full backpressure.
- Saturating SEC/DED event counters for status reporting.

Parameters:
- DATA_W, 32, data bits per word; must be >= 1.
- PAR_W, 6, Hamming parity bits; smallest value with 2^PAR_W >= DATA_W+PAR_W+1 (elaboration error otherwise).
- CNT_W, 16, width of each error counter.
- Derived: CODE_W = DATA_W+PAR_W+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enc_in_valid  in  1  write data valid.
- enc_in_ready  out  1  encoder can accept.
- enc_in_data  in  DATA_W  write data.
- enc_out_valid  out  1  codeword valid.
- enc_out_ready  in  1  downstream accepts codeword.
- enc_out_code  out  CODE_W  encoded word.
- dec_in_valid  in  1  read codeword valid.
- dec_in_ready  out  1  decoder can accept.
- dec_in_code  in  CODE_W  codeword from memory.
- dec_out_valid  out  1  decoded result valid.
- dec_out_ready  in  1  downstream accepts result.
- dec_out_data  out  DATA_W  corrected data, or raw data on DED.
- dec_out_sec  out  1  single error corrected.
- dec_out_ded  out  1  uncorrectable error.
- dec_out_syndrome  out  PAR_W  Hamming syndrome of this word.
- cnt_clr  in  1  synchronous clear of both counters.
- sec_cnt  out  CNT_W  saturating SEC count.
- ded_cnt  out  CNT_W  saturating DED count.

Behaviour:
- Reset: all valid outputs 0; enc_out_code, dec_out_* and counters 0. enc_in_ready and dec_in_ready are 1 one cycle after reset release (combinational from empty stages). Reset mid-operation discards all in-flight words.
- Codeword layout:
  - Bit 0 is overall parity (XOR of bits CODE_W-1..1).
  - Positions 1..CODE_W-1 follow standard Hamming order: power-of-two positions carry parity P(2^k) = XOR of all positions with index bit k set.
  - Data bits fill the non-power-of-two positions in ascending order, data[0] first.
- Encoder: 1 register stage, latency 1. enc_in_ready = !enc_out_valid || enc_out_ready. A word is captured on enc_in_valid && enc_in_ready. enc_out_valid drops after a handshake if no new input arrives. Output stays stable while valid && !ready.
- Decoder stage 1:
  - s = XOR of indices of all set bits in positions 1..CODE_W-1.
  - o = XOR of all CODE_W bits.
  - Registers code, s and o.
- Decoder stage 2 classification:
  - s=0, o=0: clean; sec=0, ded=0.
  - s!=0, o=1, s<=CODE_W-1: flip bit s, sec=1.
  - s=0, o=1: overall parity bit in error; data unchanged, sec=1.
  - s!=0, o=0: double error; ded=1, data uncorrected.
  - s!=0, o=1, s>CODE_W-1 (shortened code): ded=1, data uncorrected.
  - sec and ded are never both 1.
- Decoder latency and flow control:
  - Latency 2 cycles from input handshake to dec_out_valid when unstalled.
  - s2_en = !dec_out_valid || dec_out_ready; s1_en = !s1_valid || s2_en; dec_in_ready = s1_en.
  - Full throughput (1 word/cycle) when dec_out_ready is held 1.
  - Bubbles collapse; no word is dropped or duplicated under any ready pattern.
- Counters:
  - Increment once per output handshake (dec_out_valid && dec_out_ready) whose result has sec=1 (sec_cnt) or ded=1 (ded_cnt).
  - Saturate at 2^CNT_W-1.
  - cnt_clr wins over a same-cycle increment (result 0).
- Encode and decode paths are fully independent; simultaneous traffic is legal.

Test Plan:
- DATA_W=4, PAR_W=3: enc_in_data=4'b1010 -> enc_out_code=8'hA5 one cycle later. enc_in_data=4'b0000 -> 8'h00.
- Decode 8'hA5 -> after 2 cycles data=4'b1010, sec=0, ded=0, syndrome=0. Counters unchanged.
- Decode 8'h85 (bit 5 flipped) -> data=4'b1010, sec=1, syndrome=5, sec_cnt +1. Decode 8'hA4 (bit 0 flipped) -> data=4'b1010, sec=1, syndrome=0.
- Decode 8'h8D (bits 5 and 3 flipped) -> ded=1, sec=0, syndrome=6, data=4'b1001 (raw), ded_cnt +1.
- Stream 16 words with dec_out_ready random: order and values are preserved. Held output is stable while stalled. dec_in_ready=0 only when both stages are full and dec_out_ready=0.
- CNT_W=2: 5 SEC words -> sec_cnt saturates at 3. cnt_clr with a same-cycle SEC handshake -> 0. Assert rst_n low mid-stream -> all valids 0 immediately (asynchronous), counters 0.

Source files
------------

// File: rtl/ecc_secded_pipe.sv
// SECDED extended-Hamming codec: registered encoder plus a 2-stage pipelined
// decoder/corrector, both with valid/ready backpressure and saturating error counters.
module ecc_secded_pipe #(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enc_in_valid,
  output logic                            enc_in_ready,
  input  logic [DATA_W-1:0]               enc_in_data,
  output logic                            enc_out_valid,
  input  logic                            enc_out_ready,
  output logic [DATA_W+PAR_W:0]           enc_out_code,
  input  logic                            dec_in_valid,
  output logic                            dec_in_ready,
  input  logic [DATA_W+PAR_W:0]           dec_in_code,
  output logic                            dec_out_valid,
  input  logic                            dec_out_ready,
  output logic [DATA_W-1:0]               dec_out_data,
  output logic                            dec_out_sec,
  output logic                            dec_out_ded,
  output logic [PAR_W-1:0]                dec_out_syndrome,
  input  logic                            cnt_clr,
  output logic [CNT_W-1:0]                sec_cnt,
  output logic [CNT_W-1:0]                ded_cnt
);

  localparam int CODE_W = DATA_W + PAR_W + 1;
  localparam logic [PAR_W-1:0] LAST_POS = PAR_W'(CODE_W - 1);

  generate
    if (DATA_W < 1 || (2 ** PAR_W) < CODE_W || (2 ** (PAR_W - 1)) >= (DATA_W + PAR_W)) begin : g_bad_params
      $error("ecc_secded_pipe: PAR_W must be the smallest value with 2**PAR_W >= DATA_W+PAR_W+1");
    end
  endgenerate

  function automatic logic f_is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Data fills non-power-of-two positions ascending; parity bits then cover them.
  function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              par;
    int                j;
    c = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if (!f_is_pow2(p)) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int p = 1; p < CODE_W; p++) begin
        if (p[k] && !f_is_pow2(p)) par = par ^ c[p];
      end
      c[1 << k] = par;
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if (!f_is_pow2(p)) begin
        d[j] = c[p];
        j++;
      end
    end
    return d;
  endfunction

  // ---------------- encoder ----------------
  logic              r_enc_valid;
  logic [CODE_W-1:0] r_enc_code;
  logic              w_enc_take;

  assign enc_in_ready = !r_enc_valid || enc_out_ready;
  assign w_enc_take   = enc_in_valid && enc_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_valid <= 1'b0;
      r_enc_code  <= '0;
    end else if (w_enc_take) begin
      r_enc_valid <= 1'b1;
      r_enc_code  <= f_encode(enc_in_data);
    end else if (enc_out_ready) begin
      r_enc_valid <= 1'b0;
    end
  end

  assign enc_out_valid = r_enc_valid;
  assign enc_out_code  = r_enc_code;

  // ---------------- decoder stage 1 ----------------
  logic              w_s2_en;
  logic              w_s1_en;
  logic [PAR_W-1:0]  w_syn;
  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic [PAR_W-1:0]  r_s1_syn;
  logic              r_s1_ovr;

  assign w_s2_en      = !dec_out_valid || dec_out_ready;
  assign w_s1_en      = !r_s1_valid || w_s2_en;
  assign dec_in_ready = w_s1_en;

  always_comb begin
    w_syn = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (dec_in_code[p]) w_syn = w_syn ^ p[PAR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s1_ovr   <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= dec_in_valid;
      if (dec_in_valid) begin
        r_s1_code <= dec_in_code;
        r_s1_syn  <= w_syn;
        r_s1_ovr  <= ^dec_in_code;
      end
    end
  end

  // ---------------- decoder stage 2 ----------------
  logic              w_nz;
  logic              w_sec;
  logic              w_ded;
  logic [CODE_W-1:0] w_fixed;
  logic              r_dout_valid;
  logic [DATA_W-1:0] r_dout_data;
  logic              r_dout_sec;
  logic              r_dout_ded;
  logic [PAR_W-1:0]  r_dout_syn;

  // Syndromes beyond the last position only arise from multi-bit errors in a shortened code.
  assign w_nz  = |r_s1_syn;
  assign w_sec = r_s1_ovr && (!w_nz || (r_s1_syn <= LAST_POS));
  assign w_ded = w_nz && (!r_s1_ovr || (r_s1_syn > LAST_POS));

  always_comb begin
    w_fixed = r_s1_code;
    for (int p = 1; p < CODE_W; p++) begin
      if (w_sec && (r_s1_syn == PAR_W'(p))) w_fixed[p] = ~r_s1_code[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      r_dout_sec   <= 1'b0;
      r_dout_ded   <= 1'b0;
      r_dout_syn   <= '0;
    end else if (w_s2_en) begin
      r_dout_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout_data <= f_extract(w_fixed);
        r_dout_sec  <= w_sec;
        r_dout_ded  <= w_ded;
        r_dout_syn  <= r_s1_syn;
      end
    end
  end

  assign dec_out_valid    = r_dout_valid;
  assign dec_out_data     = r_dout_data;
  assign dec_out_sec      = r_dout_sec;
  assign dec_out_ded      = r_dout_ded;
  assign dec_out_syndrome = r_dout_syn;

  // ---------------- counters ----------------
  logic             w_out_hs;
  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] r_ded_cnt;

  assign w_out_hs = r_dout_valid && dec_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_dout_sec && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + CNT_W'(1);
      if (r_dout_ded && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + CNT_W'(1);
    end
  end

  assign sec_cnt = r_sec_cnt;
  assign ded_cnt = r_ded_cnt;

endmodule
